// File: rtl/rp_cmd_check.sv
// RPxx command validator: qualifies GO writes, raises ER1 set strobes,
// steps the working disk address during transfers and summarises ER1.
module rp_cmd_check #(
  parameter int NUMCYL  = 815,
  parameter int NUMTRK  = 19,
  parameter int NUMSECT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        rpGO,
  input  logic [4:0]  rpFUN,
  input  logic        rpDRY,
  input  logic        rpWRL,
  input  logic [9:0]  rpCYL,
  input  logic [5:0]  rpTA,
  input  logic [5:0]  rpSA,
  input  logic        rpINCSECT,
  input  logic [15:0] rpER1,
  output logic        rpSETILF,
  output logic        rpSETIAE,
  output logic        rpSETWLE,
  output logic        rpSETRMR,
  output logic        rpSETAOE,
  output logic        rpCMDGO,
  output logic [4:0]  rpCMDFUN,
  output logic        rpBUSY,
  output logic [9:0]  rpWCYL,
  output logic [5:0]  rpWTA,
  output logic [5:0]  rpWSA,
  output logic        rpERR
);

  localparam logic [9:0] CYL_LIM  = 10'(NUMCYL);
  localparam logic [5:0] TRK_LIM  = 6'(NUMTRK);
  localparam logic [5:0] SECT_LIM = 6'(NUMSECT);
  localparam logic [9:0] CYL_LAST  = 10'(NUMCYL - 1);
  localparam logic [5:0] TRK_LAST  = 6'(NUMTRK - 1);
  localparam logic [5:0] SECT_LAST = 6'(NUMSECT - 1);
  localparam logic [4:0] FUN_DRVCLR = 5'd4;

  typedef enum logic [1:0] {IDLE, CHECK, XFER} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  fun_reg, fun_next;
  logic [9:0]  cyl_reg, cyl_next;
  logic [5:0]  trk_reg, trk_next;
  logic [5:0]  sect_reg, sect_next;
  logic        ilf_reg, ilf_next;
  logic        iae_reg, iae_next;
  logic        wle_reg, wle_next;
  logic        rmr_reg, rmr_next;
  logic        aoe_reg, aoe_next;
  logic        go_reg, go_next;
  logic        err_reg;
  logic        dry_prev_reg;

  logic        reset_any;
  logic        is_legal, is_addr, is_write, addr_bad, wlock, dry_rise;

  assign reset_any = rst | clr;
  assign is_legal  = fun_reg inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                     5'd9, 5'd12, 5'd20, 5'd21, 5'd24, 5'd25, 5'd28, 5'd29};
  assign is_addr   = fun_reg inside {5'd2, 5'd12, 5'd20, 5'd21, 5'd24, 5'd25, 5'd28, 5'd29};
  assign is_write  = fun_reg inside {5'd24, 5'd25};
  assign addr_bad  = (cyl_reg >= CYL_LIM) | (trk_reg >= TRK_LIM) | (sect_reg >= SECT_LIM);
  assign wlock     = is_write & rpWRL;
  assign dry_rise  = rpDRY & ~dry_prev_reg;

  always_comb begin
    state_next = state_reg;
    fun_next   = fun_reg;
    cyl_next   = cyl_reg;
    trk_next   = trk_reg;
    sect_next  = sect_reg;
    ilf_next   = 1'b0;
    iae_next   = 1'b0;
    wle_next   = 1'b0;
    rmr_next   = 1'b0;
    aoe_next   = 1'b0;
    go_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rpGO) begin
          fun_next   = rpFUN;
          cyl_next   = rpCYL;
          trk_next   = rpTA;
          sect_next  = rpSA;
          state_next = CHECK;
        end
      end
      CHECK: begin
        // Drive clear must always get through so software can recover a faulted drive.
        if (fun_reg == FUN_DRVCLR) go_next = 1'b1;
        else if (!rpDRY)           rmr_next = 1'b1;
        else if (!is_legal)        ilf_next = 1'b1;
        else if (is_addr && addr_bad) begin
          iae_next = 1'b1;
          wle_next = wlock;
        end
        else if (wlock)            wle_next = 1'b1;
        else                       go_next = 1'b1;
        state_next = (go_next && fun_reg >= 5'd20) ? XFER : IDLE;
      end
      XFER: begin
        if (rpGO && rpFUN == FUN_DRVCLR) begin
          state_next = IDLE;
        end else begin
          rmr_next = rpGO;
          if (rpINCSECT) begin
            if (sect_reg == SECT_LAST) begin
              sect_next = '0;
              if (trk_reg == TRK_LAST) begin
                trk_next = '0;
                if (cyl_reg == CYL_LAST) begin
                  cyl_next   = '0;
                  aoe_next   = 1'b1;
                  state_next = IDLE;
                end else begin
                  cyl_next = cyl_reg + 10'd1;
                end
              end else begin
                trk_next = trk_reg + 6'd1;
              end
            end else begin
              sect_next = sect_reg + 6'd1;
            end
          end
          if (dry_rise) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_any) begin
      state_reg    <= IDLE;
      fun_reg      <= '0;
      cyl_reg      <= '0;
      trk_reg      <= '0;
      sect_reg     <= '0;
      ilf_reg      <= 1'b0;
      iae_reg      <= 1'b0;
      wle_reg      <= 1'b0;
      rmr_reg      <= 1'b0;
      aoe_reg      <= 1'b0;
      go_reg       <= 1'b0;
      err_reg      <= 1'b0;
      dry_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fun_reg      <= fun_next;
      cyl_reg      <= cyl_next;
      trk_reg      <= trk_next;
      sect_reg     <= sect_next;
      ilf_reg      <= ilf_next;
      iae_reg      <= iae_next;
      wle_reg      <= wle_next;
      rmr_reg      <= rmr_next;
      aoe_reg      <= aoe_next;
      go_reg       <= go_next;
      err_reg      <= |rpER1;
      dry_prev_reg <= rpDRY;
    end
  end

  assign rpSETILF = ilf_reg;
  assign rpSETIAE = iae_reg;
  assign rpSETWLE = wle_reg;
  assign rpSETRMR = rmr_reg;
  assign rpSETAOE = aoe_reg;
  assign rpCMDGO  = go_reg;
  assign rpCMDFUN = fun_reg;
  assign rpBUSY   = (state_reg != IDLE);
  assign rpWCYL   = cyl_reg;
  assign rpWTA    = trk_reg;
  assign rpWSA    = sect_reg;
  assign rpERR    = err_reg;

endmodule

// File: tb/tb_rp_cmd_check.sv
// Self-checking bench for rp_cmd_check: vector table, directed corner
// sequences and randomized commands/transfers against a reference model.
module tb_rp_cmd_check;

  localparam int NUMCYL = 815, NUMTRK = 19, NUMSECT = 20;
  localparam int TOTAL  = NUMCYL * NUMTRK * NUMSECT;

  logic        clk = 1'b0;
  logic        rst, clr, rpGO, rpDRY, rpWRL, rpINCSECT;
  logic [4:0]  rpFUN;
  logic [9:0]  rpCYL;
  logic [5:0]  rpTA, rpSA;
  logic [15:0] rpER1;
  logic        rpSETILF, rpSETIAE, rpSETWLE, rpSETRMR, rpSETAOE, rpCMDGO, rpBUSY, rpERR;
  logic [4:0]  rpCMDFUN;
  logic [9:0]  rpWCYL;
  logic [5:0]  rpWTA, rpWSA;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rp_cmd_check dut (
    .clk(clk), .rst(rst), .clr(clr), .rpGO(rpGO), .rpFUN(rpFUN), .rpDRY(rpDRY),
    .rpWRL(rpWRL), .rpCYL(rpCYL), .rpTA(rpTA), .rpSA(rpSA), .rpINCSECT(rpINCSECT),
    .rpER1(rpER1), .rpSETILF(rpSETILF), .rpSETIAE(rpSETIAE), .rpSETWLE(rpSETWLE),
    .rpSETRMR(rpSETRMR), .rpSETAOE(rpSETAOE), .rpCMDGO(rpCMDGO), .rpCMDFUN(rpCMDFUN),
    .rpBUSY(rpBUSY), .rpWCYL(rpWCYL), .rpWTA(rpWTA), .rpWSA(rpWSA), .rpERR(rpERR)
  );

  // strobe bundle order: {ilf, iae, wle, rmr, cmdgo}
  typedef struct {
    logic [4:0] fun;
    logic       dry;
    logic       wrl;
    logic [9:0] cyl;
    logic [5:0] trk;
    logic [5:0] sect;
    logic [4:0] exp_strb;
    logic       exp_xfer;
  } vec_t;

  function automatic logic [4:0] strobes();
    return {rpSETILF, rpSETIAE, rpSETWLE, rpSETRMR, rpCMDGO};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decision, written directly from the command qualification rules.
  function automatic logic [4:0] ref_strobes(input int fun, input bit dry, input bit wrl,
                                              input int cyl, input int trk, input int sect);
    bit legal, addressed, write, bad;
    legal     = fun inside {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 20, 21, 24, 25, 28, 29};
    addressed = fun inside {2, 12, 20, 21, 24, 25, 28, 29};
    write     = fun inside {24, 25};
    bad       = (cyl >= NUMCYL) || (trk >= NUMTRK) || (sect >= NUMSECT);
    if (fun == 4)              return 5'b00001;
    if (!dry)                  return 5'b00010;
    if (!legal)                return 5'b10000;
    if (addressed && bad)      return {1'b0, 1'b1, write && wrl, 2'b00};
    if (write && wrl)          return 5'b00100;
    return 5'b00001;
  endfunction

  // Issue one GO and check the 2-cycle strobe latency and single-pulse behaviour.
  task automatic do_cmd(input string tag, input logic [4:0] fun, input logic dry, input logic wrl,
                        input logic [9:0] cyl, input logic [5:0] trk, input logic [5:0] sect,
                        input logic [4:0] exp_strb, input logic exp_xfer);
    rpFUN = fun; rpDRY = dry; rpWRL = wrl; rpCYL = cyl; rpTA = trk; rpSA = sect; rpGO = 1'b1;
    tick();
    rpGO = 1'b0;
    check({tag, " busy_in_check"}, int'(rpBUSY), 1);
    check({tag, " no_early_strobe"}, int'(strobes()), 0);
    tick();
    check({tag, " strobes"}, int'(strobes()), int'(exp_strb));
    check({tag, " cmdfun"}, int'(rpCMDFUN), int'(fun));
    check({tag, " busy_after"}, int'(rpBUSY), int'(exp_xfer));
    tick();
    check({tag, " no_repeat"}, int'(strobes()), 0);
  endtask

  task automatic abort_xfer(input string tag);
    rpFUN = 5'd4; rpGO = 1'b1;
    tick();
    rpGO = 1'b0;
    check({tag, " abort_idle"}, int'(rpBUSY), 0);
    check({tag, " abort_no_strobe"}, int'({strobes(), rpSETAOE}), 0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{5'd2,  1, 0, 10'd100, 6'd5,  6'd3,  5'b00001, 0};
    vecs[1]  = '{5'd28, 1, 0, 10'd815, 6'd0,  6'd0,  5'b01000, 0};
    vecs[2]  = '{5'd24, 1, 1, 10'd815, 6'd0,  6'd0,  5'b01100, 0};
    vecs[3]  = '{5'd10, 1, 0, 10'd0,   6'd0,  6'd0,  5'b10000, 0};
    vecs[4]  = '{5'd2,  0, 0, 10'd1,   6'd1,  6'd1,  5'b00010, 0};
    vecs[5]  = '{5'd4,  0, 0, 10'd0,   6'd0,  6'd0,  5'b00001, 0};
    vecs[6]  = '{5'd25, 1, 1, 10'd10,  6'd1,  6'd1,  5'b00100, 0};
    vecs[7]  = '{5'd20, 1, 0, 10'd0,   6'd19, 6'd0,  5'b01000, 0};
    vecs[8]  = '{5'd21, 1, 0, 10'd814, 6'd18, 6'd19, 5'b00001, 1};
    vecs[9]  = '{5'd1,  1, 0, 10'd1023,6'd63, 6'd63, 5'b00001, 0};
    vecs[10] = '{5'd12, 1, 0, 10'd0,   6'd0,  6'd20, 5'b01000, 0};
    vecs[11] = '{5'd31, 0, 0, 10'd0,   6'd0,  6'd0,  5'b00010, 0};

    rst = 1'b1; clr = 1'b0; rpGO = 1'b0; rpFUN = '0; rpDRY = 1'b1; rpWRL = 1'b0;
    rpCYL = '0; rpTA = '0; rpSA = '0; rpINCSECT = 1'b0; rpER1 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset strobes", int'({strobes(), rpSETAOE}), 0);
    check("reset busy", int'(rpBUSY), 0);
    check("reset waddr", int'({rpWCYL, rpWTA, rpWSA}), 0);
    check("reset cmdfun", int'(rpCMDFUN), 0);
    check("reset err", int'(rpERR), 0);

    foreach (vecs[i]) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].fun, vecs[i].dry, vecs[i].wrl, vecs[i].cyl,
             vecs[i].trk, vecs[i].sect, vecs[i].exp_strb, vecs[i].exp_xfer);
      if (vecs[i].exp_xfer) abort_xfer($sformatf("vec%0d", i));
    end

    // Last sector of the pack: one step wraps to 0/0/0 with overflow.
    do_cmd("aoe", 5'd28, 1, 0, 10'd814, 6'd18, 6'd19, 5'b00001, 1);
    rpINCSECT = 1'b1; tick(); rpINCSECT = 1'b0;
    check("aoe waddr", int'({rpWCYL, rpWTA, rpWSA}), 0);
    check("aoe pulse", int'(rpSETAOE), 1);
    check("aoe idle", int'(rpBUSY), 0);
    tick();
    check("aoe single", int'(rpSETAOE), 0);

    // Sector wrap into the next track, then refused GO and drive-clear abort.
    do_cmd("wrap", 5'd28, 1, 0, 10'd10, 6'd3, 6'd19, 5'b00001, 1);
    rpINCSECT = 1'b1; tick(); rpINCSECT = 1'b0;
    check("wrap waddr", int'({rpWCYL, rpWTA, rpWSA}), int'({10'd10, 6'd4, 6'd0}));
    check("wrap no_aoe", int'(rpSETAOE), 0);
    rpFUN = 5'd2; rpCYL = 10'd99; rpTA = 6'd9; rpSA = 6'd9; rpGO = 1'b1; tick(); rpGO = 1'b0;
    check("xfer go rmr", int'(strobes()), int'(5'b00010));
    check("xfer go busy", int'(rpBUSY), 1);
    check("xfer go waddr", int'({rpWCYL, rpWTA, rpWSA}), int'({10'd10, 6'd4, 6'd0}));
    tick();
    check("xfer rmr single", int'(rpSETRMR), 0);
    abort_xfer("wrap");

    // Completion signalled by rpDRY rising.
    do_cmd("dry", 5'd20, 1, 0, 10'd5, 6'd5, 6'd5, 5'b00001, 1);
    rpDRY = 1'b0; tick();
    check("dry low busy", int'(rpBUSY), 1);
    rpDRY = 1'b1; tick();
    check("dry rise idle", int'(rpBUSY), 0);

    // Reset while in CHECK aborts silently.
    rpFUN = 5'd2; rpCYL = 10'd1; rpTA = 6'd1; rpSA = 6'd1; rpGO = 1'b1; tick(); rpGO = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_check strobes", int'(strobes()), 0);
    check("rst_check busy", int'(rpBUSY), 0);
    tick();
    check("rst_check later", int'(strobes()), 0);

    // clr behaves like reset.
    do_cmd("clrpre", 5'd21, 1, 0, 10'd7, 6'd7, 6'd7, 5'b00001, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr busy", int'(rpBUSY), 0);
    check("clr waddr", int'({rpWCYL, rpWTA, rpWSA, rpCMDFUN}), 0);

    rpER1 = 16'h0004;
    check("err lag", int'(rpERR), 0);
    tick();
    check("err set", int'(rpERR), 1);
    rpER1 = 16'h0000; tick();
    check("err clear", int'(rpERR), 0);

    // Randomized commands against the reference decision.
    for (int n = 0; n < 60; n++) begin
      logic [4:0] f; logic d, w; logic [9:0] c; logic [5:0] t, s; logic [4:0] e;
      f = 5'($urandom_range(0, 31));
      d = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        c = 10'($urandom_range(0, NUMCYL - 1)); t = 6'($urandom_range(0, NUMTRK - 1));
        s = 6'($urandom_range(0, NUMSECT - 1));
      end else begin
        c = 10'($urandom_range(0, 1023)); t = 6'($urandom_range(0, 63));
        s = 6'($urandom_range(0, 63));
      end
      e = ref_strobes(f, d, w, c, t, s);
      do_cmd($sformatf("rnd%0d f=%0d", n, f), f, d, w, c, t, s, e, e[0] && f >= 20);
      if (e[0] && f >= 20) abort_xfer($sformatf("rnd%0d", n));
    end

    // Randomized transfers: address modelled as a linear sector number.
    for (int n = 0; n < 12; n++) begin
      int lba, steps;
      bit done;
      lba = ($urandom_range(0, 1) == 1) ? TOTAL - int'($urandom_range(1, 40))
                                        : int'($urandom_range(0, TOTAL - 1));
      do_cmd($sformatf("xfr%0d", n), 5'd28, 1, 0, 10'(lba / (NUMTRK * NUMSECT)),
             6'((lba / NUMSECT) % NUMTRK), 6'(lba % NUMSECT), 5'b00001, 1);
      steps = $urandom_range(1, 45);
      done = 0;
      for (int k = 0; k < steps && !done; k++) begin
        bit ovf;
        rpINCSECT = 1'b1; tick(); rpINCSECT = 1'b0;
        lba = lba + 1;
        ovf = (lba == TOTAL);
        if (ovf) lba = 0;
        check($sformatf("xfr%0d step%0d addr", n, k), int'({rpWCYL, rpWTA, rpWSA}),
              int'({10'(lba / (NUMTRK * NUMSECT)), 6'((lba / NUMSECT) % NUMTRK), 6'(lba % NUMSECT)}));
        check($sformatf("xfr%0d step%0d aoe", n, k), int'(rpSETAOE), int'(ovf));
        check($sformatf("xfr%0d step%0d busy", n, k), int'(rpBUSY), int'(!ovf));
        if (ovf) done = 1;
        else if ($urandom_range(0, 2) == 0) tick();
      end
      if (!done) abort_xfer($sformatf("xfr%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
